lab5_dmem_responder: RTL

Data-memory responder for the lab5 RISC-V core. It accepts one load/store request at a time, applies a programmable number of wait states, and performs the access against an internal 256×32 word array. Sub-word stores use byte lanes, and loads are sign- or zero-extended. It sits where the core's data RAM sits, addressed by the ALU result and sized by instr[14:12].

---
 rtl/lab5_mem_pkg.sv | 9 +
 rtl/lab5_dmem_lane.sv | 37 +++
 rtl/lab5_dmem_responder.sv | 90 +++++++++
 3 files changed

// File: rtl/lab5_mem_pkg.sv
// lab5_mem_pkg: funct3 size encodings and responder FSM states shared by the dmem responder.
package lab5_mem_pkg;
  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/lab5_dmem_lane.sv
// lab5_dmem_lane: store byte-enable/merge, load extract/extend and access error decode.
module lab5_dmem_lane
  import lab5_mem_pkg::*;
(
  input  logic        we_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  size_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] word_i,
  output logic        err_o,
  output logic [3:0]  be_o,
  output logic [31:0] wword_o,
  output logic [31:0] rdata_o
);
  logic        is_b, is_h, is_w, sgn;
  logic [31:0] lanes;
  logic [15:0] half;
  logic [7:0]  byte_v;
  always_comb begin
    is_b    = size_i[1:0] == SZ_B[1:0];
    is_h    = size_i[1:0] == SZ_H[1:0];
    is_w    = size_i == SZ_W;
    sgn     = !size_i[2];
    err_o   = size_i == 3'b011 || size_i[2:1] == 2'b11 || (is_h && off_i[0]) ||
              (is_w && off_i != 2'b00) || (size_i[2] && we_i);
    be_o    = (!we_i || err_o) ? 4'b0000 : is_w ? 4'b1111 :
              is_h ? (off_i[1] ? 4'b1100 : 4'b0011) : 4'b0001 << off_i;
    // Replicating the store data puts it on every lane; the byte enables pick the live one.
    lanes   = is_b ? {4{wdata_i[7:0]}} : is_h ? {2{wdata_i[15:0]}} : wdata_i;
    wword_o = word_i;
    for (int i = 0; i < 4; i++) wword_o[8*i +: 8] = be_o[i] ? lanes[8*i +: 8] : word_i[8*i +: 8];
    half    = off_i[1] ? word_i[31:16] : word_i[15:0];
    byte_v  = word_i[8*off_i +: 8];
    rdata_o = (we_i || err_o) ? 32'h0 : is_w ? word_i :
              is_h ? {{16{half[15] & sgn}}, half} : {{24{byte_v[7] & sgn}}, byte_v};
  end
endmodule

// File: rtl/lab5_dmem_responder.sv
// lab5_dmem_responder: single-outstanding data-memory responder with programmable wait states
// over a 2**DEPTH_LOG2 x 32 word array.
module lab5_dmem_responder
  import lab5_mem_pkg::*;
#(
  parameter int WAIT_STATES = 2,
  parameter int DEPTH_LOG2  = 8
) (
  input  logic                  CLOCK_50,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [DEPTH_LOG2+1:0] req_addr,
  input  logic [2:0]            req_size,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err
);
  state_t                state_q;
  logic [3:0]            cnt_q;
  logic                  we_q, rsp_valid_q, err_q;
  logic [DEPTH_LOG2+1:0] addr_q;
  logic [2:0]            size_q;
  logic [31:0]           wdata_q, rdata_q;
  logic [31:0]           mem_q [2**DEPTH_LOG2];
  logic                  idle, accept, commit, we_d, err_d;
  logic [DEPTH_LOG2+1:0] addr_d;
  logic [2:0]            size_d;
  logic [31:0]           wdata_d, wword_d, rdata_d;
  logic [3:0]            be_d;
  assign idle      = state_q == IDLE;
  assign req_ready = rst_n && idle;
  assign accept    = req_valid && req_ready;
  // With no wait states the access commits on the accept edge, so IDLE uses the live fields.
  assign we_d      = idle ? req_we    : we_q;
  assign addr_d    = idle ? req_addr  : addr_q;
  assign size_d    = idle ? req_size  : size_q;
  assign wdata_d   = idle ? req_wdata : wdata_q;
  assign commit    = (accept && WAIT_STATES == 0) || (state_q == WAIT && cnt_q == 4'd0);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  lab5_dmem_lane u_lane (
    .we_i    (we_d),
    .off_i   (addr_d[1:0]),
    .size_i  (size_d),
    .wdata_i (wdata_d),
    .word_i  (mem_q[addr_d[DEPTH_LOG2+1:2]]),
    .err_o   (err_d),
    .be_o    (be_d),
    .wword_o (wword_d),
    .rdata_o (rdata_d)
  );
  always_ff @(posedge CLOCK_50 or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      size_q      <= 3'b000;
      wdata_q     <= 32'h0;
    end else begin
      rsp_valid_q <= commit;
      if (commit) begin
        rdata_q <= rdata_d;
        err_q   <= err_d;
      end
      case (state_q)
        IDLE: if (accept) begin
          we_q    <= req_we;
          addr_q  <= req_addr;
          size_q  <= req_size;
          wdata_q <= req_wdata;
          cnt_q   <= WAIT_STATES > 0 ? 4'(WAIT_STATES - 1) : 4'd0;
          state_q <= WAIT_STATES > 0 ? WAIT : RESP;
        end
        WAIT: if (cnt_q == 4'd0) state_q <= RESP;
              else cnt_q <= cnt_q - 4'd1;
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  always_ff @(posedge CLOCK_50)
    if (commit && |be_d) mem_q[addr_d[DEPTH_LOG2+1:2]] <= wword_d;
endmodule
